// File: rtl/inst_buffer_pkg.sv
// Shared fetch/dispatch types and defaults for the instruction buffer.
// The packet carries one fetched instruction with its PC and predicted next PC.
package inst_buffer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IB_SZ = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            valid;
  } if_dp_packet_t;

endpackage

// File: rtl/inst_buffer.sv
// 2-wide in-order instruction FIFO between fetch and dispatch.
// Stalls fetch whenever fewer than two free entries remain, so a pair always fits.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH = IB_SZ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash_valid,
  input  if_dp_packet_t [1:0]           if_ib_packet,
  input  logic [1:0]                    dp_num_take,
  output if_dp_packet_t [1:0]           ib_dp_packet,
  output logic [$clog2(IB_DEPTH):0]     ib_count,
  output logic                          stall_dp
);

  localparam int unsigned PtrW = $clog2(IB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if_dp_packet_t       mem [IB_DEPTH];
  logic [PtrW-1:0]     head, tail, slot1_ptr;
  logic [CntW-1:0]     count, n_enq, n_deq;
  logic [1:0]          n_take;
  logic                do_enq, v0, v1;

  assign v0       = if_ib_packet[0].valid;
  assign v1       = if_ib_packet[1].valid;
  assign stall_dp = count >= CntW'(IB_DEPTH - 1);
  assign ib_count = count;

  always_comb begin
    n_take    = (dp_num_take == 2'd3) ? 2'd2 : dp_num_take;
    n_deq     = (CntW'(n_take) > count) ? count : CntW'(n_take);
    do_enq    = !squash_valid && !stall_dp;
    n_enq     = do_enq ? (CntW'(v0) + CntW'(v1)) : '0;
    // A lone slot-1 instruction lands at tail, keeping the queue compact.
    slot1_ptr = tail + PtrW'(v0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PtrW'(n_deq);
      tail  <= tail + PtrW'(n_enq);
      count <= count + n_enq - n_deq;
    end
  end

  // Storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (!reset && do_enq) begin
      if (v0) mem[tail] <= if_ib_packet[0];
      if (v1) mem[slot1_ptr] <= if_ib_packet[1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (dp_num_take != 2'd3);
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ib_dp_packet[i] = '{inst: NOP, pc: '0, npc: '0, valid: 1'b0};
      if (CntW'(i) < count) begin
        ib_dp_packet[i]       = mem[head + PtrW'(i)];
        ib_dp_packet[i].valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed and random checks of inst_buffer against a queue-based reference model.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned D = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                squash_valid = 1'b0;
  if_dp_packet_t [1:0] if_ib_packet;
  logic [1:0]          dp_num_take = 2'd0;
  if_dp_packet_t [1:0] ib_dp_packet;
  logic [3:0]          ib_count;
  logic                stall_dp;

  inst_buffer #(.IB_DEPTH(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash_valid (squash_valid),
    .if_ib_packet (if_ib_packet),
    .dp_num_take  (dp_num_take),
    .ib_dp_packet (ib_dp_packet),
    .ib_count     (ib_count),
    .stall_dp     (stall_dp)
  );

  always #5 clock = ~clock;

  if_dp_packet_t q[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] next_pc = 32'h0;

  function automatic if_dp_packet_t mk(input logic [31:0] pc, input logic v);
    if_dp_packet_t p;
    p.inst  = $urandom;
    p.pc    = pc;
    p.npc   = pc + 32'd4;
    p.valid = v;
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_outputs();
    if_dp_packet_t e;
    int unsigned sz;
    sz = q.size();
    check("count", 128'(ib_count), 128'(sz));
    check("stall", 128'(stall_dp), 128'((D - sz) < 2));
    check("count_bound", 128'(ib_count <= 4'(D)), 128'(1));
    for (int i = 0; i < 2; i++) begin
      if (i < int'(sz)) begin
        e = q[i];
        e.valid = 1'b1;
      end else begin
        e = '{inst: NOP, pc: '0, npc: '0, valid: 1'b0};
      end
      check($sformatf("slot%0d", i), 128'(ib_dp_packet[i]), 128'(e));
    end
  endtask

  // One clock: apply inputs, check current outputs, advance DUT and model.
  task automatic cycle(input logic rst, input logic sq, input if_dp_packet_t p0,
                       input if_dp_packet_t p1, input logic [1:0] take);
    int unsigned n;
    logic stall_pre;
    reset = rst;
    squash_valid = sq;
    if_ib_packet[0] = p0;
    if_ib_packet[1] = p1;
    dp_num_take = take;
    #1;
    check_outputs();
    stall_pre = (D - q.size()) < 2;
    @(posedge clock);
    if (rst || sq) begin
      q.delete();
    end else begin
      n = (int'(take) < q.size()) ? int'(take) : q.size();
      repeat (n) void'(q.pop_front());
      if (!stall_pre) begin
        if (p0.valid) q.push_back(p0);
        if (p1.valid) q.push_back(p1);
      end
    end
    #1;
  endtask

  task automatic pair(input logic [1:0] take);
    if_dp_packet_t a, b;
    a = mk(next_pc, 1'b1);
    b = mk(next_pc + 32'd4, 1'b1);
    if ((D - q.size()) >= 2) next_pc += 32'd8;
    cycle(1'b0, 1'b0, a, b, take);
  endtask

  task automatic idle(input logic [1:0] take);
    cycle(1'b0, 1'b0, mk(32'hdead, 1'b0), mk(32'hbeef, 1'b0), take);
  endtask

  initial begin
    if_dp_packet_t a, b;
    logic v0, v1;
    if_ib_packet[0] = mk(0, 1'b0);
    if_ib_packet[1] = mk(0, 1'b0);
    @(posedge clock);
    #1;
    // 1: reset, two pairs
    cycle(1'b1, 1'b0, mk(0, 1'b0), mk(0, 1'b0), 2'd0);
    next_pc = 32'h0;
    pair(2'd0);
    pair(2'd0);
    check("t1_count", 128'(ib_count), 128'(4));
    check("t1_pc0", 128'(ib_dp_packet[0].pc), 128'(32'h0));
    check("t1_pc1", 128'(ib_dp_packet[1].pc), 128'(32'h4));
    // 2: take two
    idle(2'd2);
    check("t2_pc0", 128'(ib_dp_packet[0].pc), 128'(32'h8));
    check("t2_pc1", 128'(ib_dp_packet[1].pc), 128'(32'hc));
    check("t2_count", 128'(ib_count), 128'(2));
    // 3: fill to 7, then a pair is refused
    pair(2'd0);
    pair(2'd0);
    cycle(1'b0, 1'b0, mk(next_pc, 1'b1), mk(32'h0, 1'b0), 2'd0);
    next_pc += 32'd4;
    check("t3_stall", 128'(stall_dp), 128'(1));
    pair(2'd0);
    check("t3_count", 128'(ib_count), 128'(7));
    // 4: steady state at 6 across pointer wrap
    idle(2'd1);
    repeat (20) pair(2'd2);
    check("t4_count", 128'(ib_count), 128'(6));
    // 5: squash at count 5
    idle(2'd1);
    cycle(1'b0, 1'b1, mk(32'h900, 1'b1), mk(32'h904, 1'b1), 2'd2);
    check("t5_count", 128'(ib_count), 128'(0));
    check("t5_valid", 128'(ib_dp_packet[0].valid), 128'(0));
    next_pc = 32'h100;
    pair(2'd0);
    check("t5_pc0", 128'(ib_dp_packet[0].pc), 128'(32'h100));
    check("t5_pc1", 128'(ib_dp_packet[1].pc), 128'(32'h104));
    // 6: lone slot-1 instruction, then reset at count 3
    cycle(1'b1, 1'b0, mk(0, 1'b0), mk(0, 1'b0), 2'd0);
    cycle(1'b0, 1'b0, mk(32'h20, 1'b1), mk(0, 1'b0), 2'd0);
    cycle(1'b0, 1'b0, mk(32'h0, 1'b0), mk(32'h24, 1'b1), 2'd1);
    check("t6_count", 128'(ib_count), 128'(1));
    check("t6_pc0", 128'(ib_dp_packet[0].pc), 128'(32'h24));
    next_pc = 32'h28;
    pair(2'd0);
    check("t6_count3", 128'(ib_count), 128'(3));
    cycle(1'b1, 1'b0, mk(0, 1'b0), mk(0, 1'b0), 2'd0);
    check("t6_rst_count", 128'(ib_count), 128'(0));
    check("t6_rst_stall", 128'(stall_dp), 128'(0));
    // Random traffic
    next_pc = 32'h1000;
    for (int k = 0; k < 400; k++) begin
      v0 = $urandom_range(0, 3) != 0;
      v1 = $urandom_range(0, 3) != 0;
      a = mk(next_pc, v0);
      b = mk(next_pc + (v0 ? 32'd4 : 32'd0), v1);
      if ((D - q.size()) >= 2) next_pc += 32'd4 * (32'(v0) + 32'(v1));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, a, b,
            2'($urandom_range(0, 2)));
    end
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
